// File: rtl/la_clbcfg.sv
`default_nettype none
// la_clbcfg: word-serial configuration loader for one CLB tile; shadow assembly, length/XOR check, atomic commit.
// Revision 1.0
module la_clbcfg #(
    parameter int N = 1,
    parameter int I = 8,
    parameter int K = 4,
    parameter int W = 8,
    localparam int SI  = $clog2(I),
    localparam int SN  = $clog2(N),
    localparam int FBW = (SN > 0) ? N*K*SN : 1
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              cfg_valid,
    input  logic [W-1:0]      cfg_data,
    input  logic              cfg_last,
    output logic              cfg_ready,
    output logic [N*16-1:0]   cfglut,
    output logic [N-1:0]      cfgbp,
    output logic [N*K*SI-1:0] cfgin,
    output logic [FBW-1:0]    cfgfb,
    output logic [N*K-1:0]    cfgloc,
    output logic              done,
    output logic              err,
    output logic              loaded
);

    localparam int CW   = N*16 + N + N*K*SI + N*K*SN + N*K;
    localparam int NW   = (CW + W - 1) / W;
    localparam int CNTW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NW - 1);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_SUM    = 2'd1,
        S_COMMIT = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t          state;
    logic [CNTW-1:0] cnt;
    logic [W-1:0]    sum;
    logic [CW-1:0]   shadow;
    logic            xfer;
    logic            shadow_we;

    assign xfer      = cfg_valid && cfg_ready;
    assign shadow_we = (state == S_LOAD) && xfer && !cfg_last;

    // Each data word owns its slice; the last word's bits above CW are dropped here.
    for (genvar k = 0; k < NW; k++) begin : g_word
        localparam int WB = (CW - k*W < W) ? CW - k*W : W;
        always_ff @(posedge clk) begin
            if (shadow_we && cnt == CNTW'(k))
                shadow[k*W +: WB] <= cfg_data[WB-1:0];
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= S_LOAD;
            cnt       <= '0;
            sum       <= '0;
            cfg_ready <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            loaded    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (xfer) begin
                        if (cfg_last) begin
                            err <= 1'b1;
                            cnt <= '0;
                            sum <= '0;
                        end else if (cnt == LAST_CNT) begin
                            state <= S_SUM;
                            cnt   <= '0;
                            sum   <= sum ^ cfg_data;
                        end else begin
                            cnt <= cnt + 1'b1;
                            sum <= sum ^ cfg_data;
                        end
                    end
                end
                S_SUM: begin
                    if (xfer) begin
                        sum <= '0;
                        if (!cfg_last) begin
                            err   <= 1'b1;
                            state <= S_DRAIN;
                        end else if (cfg_data == sum) begin
                            state     <= S_COMMIT;
                            cfg_ready <= 1'b0;
                        end else begin
                            err   <= 1'b1;
                            state <= S_LOAD;
                        end
                    end
                end
                S_COMMIT: begin
                    state     <= S_LOAD;
                    cfg_ready <= 1'b1;
                    done      <= 1'b1;
                    loaded    <= 1'b1;
                end
                S_DRAIN: begin
                    if (xfer && cfg_last)
                        state <= S_LOAD;
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    // Active configuration only moves during COMMIT, so rejected frames never disturb the tile.
    if (SN > 0) begin : g_fb
        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset)
                {cfgloc, cfgfb, cfgin, cfgbp, cfglut} <= '0;
            else if (state == S_COMMIT)
                {cfgloc, cfgfb, cfgin, cfgbp, cfglut} <= shadow;
        end
    end else begin : g_nofb
        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset)
                {cfgloc, cfgin, cfgbp, cfglut} <= '0;
            else if (state == S_COMMIT)
                {cfgloc, cfgin, cfgbp, cfglut} <= shadow;
        end
        assign cfgfb = '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_la_clbcfg.sv
`default_nettype none
`timescale 1ns/1ps
// tb_la_clbcfg: randomized frame-level bench for la_clbcfg with N=2, I=8, W=8 (CW=74, NW=10).
module tb_la_clbcfg;

    localparam int N  = 2;
    localparam int I  = 8;
    localparam int K  = 4;
    localparam int W  = 8;
    localparam int CW = 74;
    localparam int NW = 10;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [7:0]  cfg_data = 8'h00;
    logic        cfg_last = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfglut;
    logic [1:0]  cfgbp;
    logic [23:0] cfgin;
    logic [7:0]  cfgfb;
    logic [7:0]  cfgloc;
    logic        done;
    logic        err;
    logic        loaded;

    la_clbcfg #(.N(N), .I(I), .K(K), .W(W)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_last  (cfg_last),
        .cfg_ready (cfg_ready),
        .cfglut    (cfglut),
        .cfgbp     (cfgbp),
        .cfgin     (cfgin),
        .cfgfb     (cfgfb),
        .cfgloc    (cfgloc),
        .done      (done),
        .err       (err),
        .loaded    (loaded)
    );

    always #5 clk = ~clk;

    logic [CW-1:0] act;
    assign act = {cfgloc, cfgfb, cfgin, cfgbp, cfglut};

    int total = 0;
    int bad = 0;
    int n_done = 0;
    int n_err = 0;
    int n_both = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (done) n_done++;
        if (err) n_err++;
        if (done && err) n_both++;
    end

    // Reference model: the image a frame carries and the configuration the tile should hold.
    logic [CW-1:0]   exp_cfg = '0;
    logic            exp_loaded = 1'b0;
    logic [W-1:0]    frame [NW+1];
    logic [CW-1:0]   frame_cfg;

    function automatic logic [NW*W-1:0] rand_image();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[NW*W-1:0];
    endfunction

    task automatic build_frame(input logic [NW*W-1:0] img);
        logic [W-1:0] x;
        x = '0;
        for (int k = 0; k < NW; k++) begin
            frame[k] = img[k*W +: W];
            x = x ^ img[k*W +: W];
        end
        frame[NW] = x;
        frame_cfg = img[CW-1:0];
    endtask

    task automatic xfer_word(input logic [7:0] d, input logic lst, input int gap_pct, output int stalls);
        int g;
        g = 0;
        stalls = 0;
        while (gap_pct > 0 && g < 8 && $urandom_range(99) < gap_pct) begin
            cfg_valid = 1'b0;
            cfg_data  = 8'($urandom);
            cfg_last  = 1'($urandom);
            @(posedge clk); #1;
            g++;
        end
        cfg_valid = 1'b1;
        cfg_data  = d;
        cfg_last  = lst;
        while (!cfg_ready) begin
            @(posedge clk); #1;
            stalls++;
            if (stalls > 50) begin
                total++;
                bad++;
                $display("FAIL xfer_timeout: cfg_ready stayed %b, want 1 within 50 cycles", cfg_ready);
                cfg_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic send_frame(input int gap_pct);
        int s;
        for (int k = 0; k <= NW; k++)
            xfer_word(frame[k], k == NW, gap_pct, s);
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        repeat (3) @(posedge clk);
        #1 nreset = 1'b1;
        @(posedge clk); #1;
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", cfg_ready); end
        total++; if (act !== '0) begin bad++; $display("FAIL reset_cfg: got %h want 0", act); end
        total++; if (loaded !== 1'b0) begin bad++; $display("FAIL reset_loaded: got %b want 0", loaded); end
        repeat (5) @(posedge clk); #1;
        total++; if (n_done !== 0 || n_err !== 0) begin bad++; $display("FAIL reset_pulses: got done=%0d err=%0d want 0/0", n_done, n_err); end
    endtask

    task automatic test_good_frame();
        int d0, e0;
        d0 = n_done; e0 = n_err;
        build_frame({6'b0, 8'h00, 8'h00, 24'b111_110_101_100_011_010_001_000, 2'b11, 32'hFFFE_8000});
        send_frame(0);
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL good_ready_low: got %b want 0", cfg_ready); end
        total++; if (act !== exp_cfg) begin bad++; $display("FAIL good_early: got %h want %h", act, exp_cfg); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL good_done_early: got %b want 0", done); end
        @(posedge clk); #1;
        exp_cfg = frame_cfg;
        exp_loaded = 1'b1;
        total++; if (act !== exp_cfg) begin bad++; $display("FAIL good_cfg: got %h want %h", act, exp_cfg); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL good_done: got %b want 1", done); end
        total++; if (loaded !== exp_loaded) begin bad++; $display("FAIL good_loaded: got %b want %b", loaded, exp_loaded); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL good_ready_back: got %b want 1", cfg_ready); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL good_done_drop: got %b want 0", done); end
        total++; if (n_done - d0 !== 1 || n_err - e0 !== 0) begin bad++; $display("FAIL good_pulses: got done=%0d err=%0d want 1/0", n_done - d0, n_err - e0); end
    endtask

    task automatic test_checksum_mismatch();
        int d0, e0;
        d0 = n_done; e0 = n_err;
        build_frame(rand_image());
        frame[NW] = frame[NW] ^ 8'h01;
        send_frame(0);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL sum_err: got %b want 1", err); end
        repeat (3) @(posedge clk); #1;
        total++; if (act !== exp_cfg) begin bad++; $display("FAIL sum_keep: got %h want %h", act, exp_cfg); end
        total++; if (loaded !== exp_loaded) begin bad++; $display("FAIL sum_loaded: got %b want %b", loaded, exp_loaded); end
        total++; if (n_done - d0 !== 0 || n_err - e0 !== 1) begin bad++; $display("FAIL sum_pulses: got done=%0d err=%0d want 0/1", n_done - d0, n_err - e0); end
    endtask

    task automatic test_short_frame();
        int d0, e0, s;
        d0 = n_done; e0 = n_err;
        build_frame(rand_image());
        for (int k = 0; k < 4; k++) xfer_word(frame[k], k == 3, 0, s);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL short_err: got %b want 1", err); end
        build_frame(rand_image());
        send_frame(0);
        repeat (2) @(posedge clk); #1;
        exp_cfg = frame_cfg;
        total++; if (act !== exp_cfg) begin bad++; $display("FAIL short_next_cfg: got %h want %h", act, exp_cfg); end
        total++; if (n_done - d0 !== 1 || n_err - e0 !== 1) begin bad++; $display("FAIL short_pulses: got done=%0d err=%0d want 1/1", n_done - d0, n_err - e0); end
    endtask

    task automatic test_long_frame();
        int d0, e0, s;
        d0 = n_done; e0 = n_err;
        build_frame(rand_image());
        for (int k = 0; k <= NW; k++) xfer_word(frame[k], 1'b0, 0, s);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL long_err: got %b want 1", err); end
        xfer_word(8'($urandom), 1'b1, 0, s);
        repeat (4) @(posedge clk); #1;
        total++; if (act !== exp_cfg) begin bad++; $display("FAIL long_keep: got %h want %h", act, exp_cfg); end
        total++; if (n_done - d0 !== 0 || n_err - e0 !== 1) begin bad++; $display("FAIL long_pulses: got done=%0d err=%0d want 0/1", n_done - d0, n_err - e0); end
    endtask

    task automatic test_backpressure();
        int d0, e0, s;
        logic [CW-1:0] cfg_a;
        d0 = n_done; e0 = n_err;
        build_frame(rand_image());
        send_frame(40);
        cfg_a = frame_cfg;
        build_frame(rand_image());
        xfer_word(frame[0], 1'b0, 0, s);
        total++; if (s !== 1) begin bad++; $display("FAIL bp_stall: got %0d stall cycles want 1", s); end
        total++; if (act !== cfg_a) begin bad++; $display("FAIL bp_cfg_a: got %h want %h", act, cfg_a); end
        for (int k = 1; k <= NW; k++) xfer_word(frame[k], k == NW, 40, s);
        repeat (2) @(posedge clk); #1;
        exp_cfg = frame_cfg;
        total++; if (act !== exp_cfg) begin bad++; $display("FAIL bp_cfg_b: got %h want %h", act, exp_cfg); end
        total++; if (n_done - d0 !== 2 || n_err - e0 !== 0) begin bad++; $display("FAIL bp_pulses: got done=%0d err=%0d want 2/0", n_done - d0, n_err - e0); end
    endtask

    task automatic test_reset_mid_frame();
        int s;
        build_frame(rand_image());
        for (int k = 0; k < 6; k++) xfer_word(frame[k], 1'b0, 0, s);
        nreset = 1'b0;
        #2;
        exp_cfg = '0;
        exp_loaded = 1'b0;
        total++; if (act !== exp_cfg) begin bad++; $display("FAIL rst_mid_cfg: got %h want %h", act, exp_cfg); end
        total++; if (loaded !== exp_loaded) begin bad++; $display("FAIL rst_mid_loaded: got %b want 0", loaded); end
        @(posedge clk); #3 nreset = 1'b1;
        @(posedge clk); #1;
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready: got %b want 1", cfg_ready); end
        build_frame(rand_image());
        send_frame(0);
        repeat (2) @(posedge clk); #1;
        exp_cfg = frame_cfg;
        exp_loaded = 1'b1;
        total++; if (act !== exp_cfg) begin bad++; $display("FAIL rst_mid_fresh: got %h want %h", act, exp_cfg); end
        total++; if (loaded !== exp_loaded) begin bad++; $display("FAIL rst_mid_reload: got %b want 1", loaded); end
    endtask

    task automatic test_back_to_back();
        int d0, c0;
        d0 = n_done;
        c0 = cyc;
        for (int f = 0; f < 3; f++) begin
            build_frame(rand_image());
            send_frame(0);
        end
        total++; if (cyc - c0 !== 3*(NW+2) - 1) begin bad++; $display("FAIL b2b_cycles: got %0d want %0d", cyc - c0, 3*(NW+2) - 1); end
        repeat (2) @(posedge clk); #1;
        exp_cfg = frame_cfg;
        total++; if (act !== exp_cfg) begin bad++; $display("FAIL b2b_cfg: got %h want %h", act, exp_cfg); end
        total++; if (n_done - d0 !== 3) begin bad++; $display("FAIL b2b_done: got %0d want 3", n_done - d0); end
        total++; if (n_both !== 0) begin bad++; $display("FAIL done_err_overlap: got %0d want 0", n_both); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_checksum_mismatch();
        test_short_frame();
        test_long_frame();
        test_backpressure();
        test_reset_mid_frame();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
